// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings and the default-slave state type.
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StErr1,
        StErr2
    } ds_state_e;

    // True for transfers that carry data and therefore demand a real response.
    function automatic logic trans_active(input logic [1:0] htrans);
        logic active;
        unique case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
            default:                   active = 1'b0;
        endcase
        return active;
    endfunction

endpackage

// File: rtl/ahb3lite_default_slave.sv
// Default slave for unmapped space: two-cycle ERROR response plus fault address/count logging.
module ahb3lite_default_slave #(
    parameter int unsigned HADDR_SIZE = 32,
    parameter int unsigned ERRCNT_W   = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HREADY,
    input  logic                  miss,
    input  logic [1:0]            HTRANS,
    input  logic [HADDR_SIZE-1:0] HADDR,
    output logic                  hreadyout,
    output logic                  hresp,
    output logic [HADDR_SIZE-1:0] err_addr,
    output logic [ERRCNT_W-1:0]   err_count
);

    import ahb3lite_pkg::*;

    ds_state_e             state_q, state_d;
    logic                  hreadyout_q, hreadyout_d;
    logic                  hresp_q, hresp_d;
    logic [HADDR_SIZE-1:0] err_addr_q, err_addr_d;
    logic [ERRCNT_W-1:0]   err_count_q, err_count_d;
    logic                  fault;

    assign fault = HREADY && miss && trans_active(HTRANS);

    always_comb begin
        state_d     = state_q;
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;

        unique case (state_q)
            StIdle:  if (fault) state_d = StErr1;
            StErr1:  state_d = StErr2;
            StErr2:  state_d = fault ? StErr1 : StIdle;
            default: state_d = StIdle;
        endcase

        // Entering ERR1 only ever happens on a freshly sampled fault.
        if (state_d == StErr1) begin
            err_addr_d = HADDR;
            if (err_count_q != '1) begin
                err_count_d = err_count_q + 1'b1;
            end
        end

        unique case (state_d)
            StErr1: begin
                hreadyout_d = 1'b0;
                hresp_d     = HRESP_ERROR;
            end
            StErr2: begin
                hreadyout_d = 1'b1;
                hresp_d     = HRESP_ERROR;
            end
            default: begin
                hreadyout_d = 1'b1;
                hresp_d     = HRESP_OKAY;
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= StIdle;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            err_addr_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

    assign hreadyout = hreadyout_q;
    assign hresp     = hresp_q;
    assign err_addr  = err_addr_q;
    assign err_count = err_count_q;

endmodule

// File: rtl/ahb3lite_slave_mux_n.sv
// AHB3-Lite address decoder and data-phase response mux for NUM_SLAVES slaves plus a default slave.
module ahb3lite_slave_mux_n #(
    parameter int unsigned                        HADDR_SIZE = 32,
    parameter int unsigned                        HDATA_SIZE = 32,
    parameter int unsigned                        NUM_SLAVES = 2,
    parameter logic [NUM_SLAVES*HADDR_SIZE-1:0]   SLV_BASE   = {32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*HADDR_SIZE-1:0]   SLV_MASK   = {32'hF000_0000, 32'hFFFF_0000},
    parameter int unsigned                        ERRCNT_W   = 16
) (
    input  logic                            HCLK,
    input  logic                            HRESET,
    input  logic                            HSEL,
    input  logic [HADDR_SIZE-1:0]           HADDR,
    input  logic [HDATA_SIZE-1:0]           HWDATA,
    input  logic                            HWRITE,
    input  logic [2:0]                      HSIZE,
    input  logic [2:0]                      HBURST,
    input  logic [3:0]                      HPROT,
    input  logic [1:0]                      HTRANS,
    input  logic                            HREADY,
    output logic                            HREADYOUT,
    output logic                            HRESP,
    output logic [HDATA_SIZE-1:0]           HRDATA,
    output logic [NUM_SLAVES-1:0]           s_hsel,
    output logic [HADDR_SIZE-1:0]           s_haddr,
    output logic [HDATA_SIZE-1:0]           s_hwdata,
    output logic                            s_hwrite,
    output logic [2:0]                      s_hsize,
    output logic [2:0]                      s_hburst,
    output logic [3:0]                      s_hprot,
    output logic [1:0]                      s_htrans,
    output logic                            s_hready,
    input  logic [NUM_SLAVES*HDATA_SIZE-1:0] s_hrdata,
    input  logic [NUM_SLAVES-1:0]           s_hreadyout,
    input  logic [NUM_SLAVES-1:0]           s_hresp,
    output logic [HADDR_SIZE-1:0]           err_addr,
    output logic [ERRCNT_W-1:0]             err_count
);

    import ahb3lite_pkg::*;

    logic [NUM_SLAVES-1:0] hit;
    logic [NUM_SLAVES-1:0] winner;
    logic                  miss;

    logic [NUM_SLAVES-1:0] dsel_slv_q, dsel_slv_d;
    logic                  dsel_def_q, dsel_def_d;
    logic                  dsel_none_q, dsel_none_d;

    logic                  ds_hreadyout;
    logic                  ds_hresp;

    always_comb begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
            hit[i] = HSEL && ((HADDR & SLV_MASK[i*HADDR_SIZE +: HADDR_SIZE])
                              == SLV_BASE[i*HADDR_SIZE +: HADDR_SIZE]);
        end
    end

    // Isolate the lowest set bit so overlapping regions resolve to the lowest index.
    assign winner = hit & (~hit + 1'b1);
    assign miss   = HSEL && (hit == '0);

    always_comb begin
        dsel_slv_d  = dsel_slv_q;
        dsel_def_d  = dsel_def_q;
        dsel_none_d = dsel_none_q;
        if (HREADY) begin
            dsel_slv_d  = winner;
            dsel_def_d  = miss;
            dsel_none_d = !HSEL;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dsel_slv_q  <= '0;
            dsel_def_q  <= 1'b0;
            dsel_none_q <= 1'b1;
        end else begin
            dsel_slv_q  <= dsel_slv_d;
            dsel_def_q  <= dsel_def_d;
            dsel_none_q <= dsel_none_d;
        end
    end

    ahb3lite_default_slave #(
        .HADDR_SIZE (HADDR_SIZE),
        .ERRCNT_W   (ERRCNT_W)
    ) u_default_slave (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HREADY    (HREADY),
        .miss      (miss),
        .HTRANS    (HTRANS),
        .HADDR     (HADDR),
        .hreadyout (ds_hreadyout),
        .hresp     (ds_hresp),
        .err_addr  (err_addr),
        .err_count (err_count)
    );

    always_comb begin
        HRDATA    = '0;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        if (!dsel_none_q) begin
            if (dsel_def_q) begin
                HREADYOUT = ds_hreadyout;
                HRESP     = ds_hresp;
            end else begin
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    if (dsel_slv_q[i]) begin
                        HRDATA    = s_hrdata[i*HDATA_SIZE +: HDATA_SIZE];
                        HREADYOUT = s_hreadyout[i];
                        HRESP     = s_hresp[i];
                    end
                end
            end
        end
    end

    assign s_hsel   = winner;
    assign s_haddr  = HADDR;
    assign s_hwdata = HWDATA;
    assign s_hwrite = HWRITE;
    assign s_hsize  = HSIZE;
    assign s_hburst = HBURST;
    assign s_hprot  = HPROT;
    assign s_htrans = HTRANS;
    assign s_hready = HREADY;

endmodule

// File: doc/ahb3lite_slave_mux_n.md
# ahb3lite_slave_mux_n

Parametrised AHB3-Lite decoder and response multiplexer connecting one master to NUM_SLAVES memory-mapped slaves (SRAM, flash, peripherals) in the memory subsystem. The data-phase response mux is driven by a select registered at the address phase, so responses stay correctly aligned under wait states. An internal default slave answers unmapped transfers with the two-cycle AHB ERROR response and logs the fault address and a saturating fault count.

## Interface
- HADDR_SIZE, 32, address width
- HDATA_SIZE, 32, data width
- NUM_SLAVES, 2, number of mapped slaves (1..16)
- SLV_BASE, {32'h1000_0000, 32'h0000_0000}, packed NUM_SLAVES×HADDR_SIZE base array; index 0 in the LSBs
- SLV_MASK, {32'hF000_0000, 32'hFFFF_0000}, packed mask array, same layout
- ERRCNT_W, 16, fault counter width
---
- HCLK  in  1  bus clock; all state updates on the rising edge
- HRESET  in  1  asynchronous, active-high reset
- HSEL, HADDR, HWDATA, HWRITE, HSIZE[2:0], HBURST[2:0], HPROT[3:0], HTRANS[1:0]  in  —  master address/control/data
- HREADY  in  1  bus-level HREADY, fed back from HREADYOUT by the top level
- HREADYOUT  out  1  data-phase ready to master
- HRESP  out  1  0 = OKAY, 1 = ERROR
- HRDATA  out  HDATA_SIZE  read data
- s_hsel  out  NUM_SLAVES  one-hot slave select
- s_haddr, s_hwdata, s_hwrite, s_hsize, s_hburst, s_hprot, s_htrans  out  —  broadcast copies of master signals
- s_hready  out  1  copy of HREADY
- s_hrdata  in  NUM_SLAVES×HDATA_SIZE  packed slave read data
- s_hreadyout, s_hresp  in  NUM_SLAVES  per-slave response
- err_addr  out  HADDR_SIZE  address of the most recent unmapped NONSEQ/SEQ transfer
- err_count  out  ERRCNT_W  saturating count of unmapped transfers

## Operation
- Decode: hit[i] = HSEL && ((HADDR & SLV_MASK[i]) == SLV_BASE[i]). Overlapping regions resolve to the lowest index. s_hsel carries the one-hot winner, or zero when nothing hits. miss = HSEL && no hit.
- The data-phase select dsel (one-hot across NUM_SLAVES, plus a def bit and a none bit) loads only when HREADY=1:
  - dsel = winner when a slave hits
  - def when miss
  - none when HSEL=0
- dsel holds while HREADY=0.
- Response mux, from dsel:
  - slave i: forward s_hrdata[i], s_hreadyout[i], s_hresp[i]
  - none: HRDATA=0, HREADYOUT=1, HRESP=0
  - def: default-slave outputs, with HRDATA=0
- Default slave sub-FSM (states IDLE, ERR1, ERR2):
  - IDLE→ERR1 when HREADY && miss && HTRANS[1]=1 (NONSEQ/SEQ)
  - ERR1→ERR2 unconditionally
  - ERR2→IDLE, or ERR2→ERR1 if another miss with NONSEQ/SEQ is sampled with HREADY=1
- Default-slave outputs:
  - IDLE: HREADYOUT=1, HRESP=0. IDLE/BUSY transfers to unmapped space get a zero-wait OKAY.
  - ERR1: HREADYOUT=0, HRESP=1
  - ERR2: HREADYOUT=1, HRESP=1
- Fault logging: on each IDLE→ERR1 or ERR2→ERR1 transition, err_addr ← HADDR and err_count increments, saturating at all-ones.

## Timing
- Decode and s_hsel are combinational from HADDR/HSEL in the same cycle, with zero latency.
- The response mux adds no cycle; its select is the register captured on the previous HREADY=1 edge.
- ERROR response:
  - Exactly two data-phase cycles: ERR1, then ERR2.
  - HRESP=1 in both cycles.
  - HREADYOUT low only in ERR1.
  - Back-to-back faults yield repeated ERR1/ERR2 pairs with no IDLE gap.
- HRESET asserted, including mid-error: dsel=none, FSM=IDLE, err_addr=0, err_count=0. Outputs are then HREADYOUT=1, HRESP=0, HRDATA=0 immediately, asynchronously.
- A slave that inserts wait states (s_hreadyout=0) freezes dsel, so the following address phase cannot re-steer the mux until HREADY=1.

## Structure
- Package ahb3lite_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ
  - HRESP_OKAY/ERROR
  - default-slave state enum
- Sub-module ahb3lite_default_slave:
  - contains the FSM plus err_addr and err_count
  - inputs: HCLK, HRESET, HREADY, miss, HTRANS, HADDR
  - outputs: hreadyout, hresp, err_addr, err_count
- The top level holds the decode, dsel and response mux.

## Test plan
- Reset release, then read 0x0000_0010 while slave0 returns 0xDEAD_BEEF with one wait state -> s_hsel=2'b01; HREADYOUT low for 1 cycle, then HRDATA=0xDEAD_BEEF with HRESP=0.
- Back-to-back NONSEQ to 0x0000_0004 then 0x1000_0008, with slave0 stalling 2 cycles -> the second address phase is held; slave1 data appears only after slave0 completes; no data crossover.
- NONSEQ read to unmapped 0x2000_0000 -> data phase HREADYOUT/HRESP = 0/1 then 1/1; err_addr=0x2000_0000; err_count=1.
- IDLE transfer to 0x2000_0000 -> zero-wait OKAY; err_count unchanged.
- With ERRCNT_W=2, five consecutive unmapped NONSEQ transfers -> five ERR1/ERR2 pairs; err_count saturates at 3.
- HRESET asserted during ERR1 -> HREADYOUT=1, HRESP=0 asynchronously; err_count=0; FSM=IDLE after release.
